// File: rtl/vball_gfx_arb.sv
// Graphics-ROM arbiter: BG priority with a sprite anti-starvation run limit, per-read watchdog, BG deadline monitor.
// Latency req->valid 3 cycles minimum; requesters hold req/addr until their valid, rom_req holds until ack or abort.
module vball_gfx_arb #(
    parameter int AW          = 19,
    parameter int DW          = 8,
    parameter int TIMEOUT     = 15,
    parameter int BG_RUN_MAX  = 4,
    parameter int BG_DEADLINE = 8
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          bg_read,
    input  logic [AW-1:0] bg_addr,
    output logic [DW-1:0] bg_data,
    output logic          bg_valid,
    input  logic          spr_read,
    input  logic [AW-1:0] spr_addr,
    output logic [DW-1:0] spr_data,
    output logic          spr_valid,
    output logic [AW-1:0] rom_addr,
    output logic          rom_req,
    input  logic          rom_ack,
    input  logic [DW-1:0] rom_data,
    output logic          busy,
    output logic          timeout_err,
    output logic          bg_late
);

    localparam int RW  = $clog2(BG_RUN_MAX + 1);
    localparam int DLW = $clog2(BG_DEADLINE + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [AW-1:0]   rom_addr_q, rom_addr_d;
    logic            rom_req_q, rom_req_d;
    logic [7:0]      wdog_q, wdog_d;
    logic [RW-1:0]   bg_run_q, bg_run_d;
    logic [DW-1:0]   bg_data_q, bg_data_d, spr_data_q, spr_data_d;
    logic            bg_valid_q, bg_valid_d, spr_valid_q, spr_valid_d;
    logic            timeout_err_q, timeout_err_d;
    logic            bg_srv_q, bg_srv_d, spr_srv_q, spr_srv_d;
    logic [AW-1:0]   bg_srv_addr_q, bg_srv_addr_d, spr_srv_addr_q, spr_srv_addr_d;
    logic            bg_read_q, spr_read_q;
    logic            dl_act_q, dl_act_d;
    logic [DLW-1:0]  dl_cnt_q, dl_cnt_d;
    logic            bg_late_q, bg_late_d;

    logic            bg_pend, spr_pend, grant_spr, done;
    logic [DW-1:0]   done_dat;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rom_addr_d     = rom_addr_q;
        rom_req_d      = rom_req_q;
        wdog_d         = wdog_q;
        bg_run_d       = bg_run_q;
        bg_data_d      = bg_data_q;
        spr_data_d     = spr_data_q;
        bg_valid_d     = 1'b0;
        spr_valid_d    = 1'b0;
        timeout_err_d  = 1'b0;
        bg_srv_d       = bg_srv_q;
        spr_srv_d      = spr_srv_q;
        bg_srv_addr_d  = bg_srv_addr_q;
        spr_srv_addr_d = spr_srv_addr_q;
        dl_act_d       = dl_act_q;
        dl_cnt_d       = dl_cnt_q;
        bg_late_d      = bg_late_q;
        grant_spr      = 1'b0;
        done           = 1'b0;
        done_dat       = '0;

        // A request must be seen on two consecutive samples before it can be granted.
        bg_pend  = bg_read && bg_read_q && !(bg_srv_q && (bg_addr == bg_srv_addr_q));
        spr_pend = spr_read && spr_read_q && !(spr_srv_q && (spr_addr == spr_srv_addr_q));

        if (!bg_read || (bg_addr != bg_srv_addr_q)) begin
            bg_srv_d = 1'b0;
        end
        if (!spr_read || (spr_addr != spr_srv_addr_q)) begin
            spr_srv_d = 1'b0;
        end
        if (!spr_pend) begin
            bg_run_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (bg_pend || spr_pend) begin
                    grant_spr  = spr_pend && (!bg_pend || (bg_run_q == RW'(BG_RUN_MAX)));
                    owner_d    = grant_spr;
                    rom_addr_d = grant_spr ? spr_addr : bg_addr;
                    rom_req_d  = 1'b1;
                    wdog_d     = '0;
                    state_d    = S_WAIT;
                    if (grant_spr) begin
                        bg_run_d = '0;
                    end else if (spr_pend && (bg_run_q != RW'(BG_RUN_MAX))) begin
                        bg_run_d = bg_run_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                done     = rom_ack || (wdog_q == 8'(TIMEOUT - 1));
                done_dat = rom_ack ? rom_data : {DW{1'b1}};
                if (done) begin
                    rom_req_d     = 1'b0;
                    state_d       = S_IDLE;
                    timeout_err_d = !rom_ack;
                    if (owner_q) begin
                        spr_data_d     = done_dat;
                        spr_valid_d    = 1'b1;
                        spr_srv_d      = 1'b1;
                        spr_srv_addr_d = rom_addr_q;
                    end else begin
                        bg_data_d      = done_dat;
                        bg_valid_d     = 1'b1;
                        bg_srv_d       = 1'b1;
                        bg_srv_addr_d  = rom_addr_q;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Deadline window opens on a fresh BG request and closes on its valid.
        if (dl_act_q) begin
            if (bg_valid_q) begin
                dl_act_d = 1'b0;
            end else if (dl_cnt_q == DLW'(BG_DEADLINE)) begin
                bg_late_d = 1'b1;
                dl_act_d  = 1'b0;
            end else begin
                dl_cnt_d = dl_cnt_q + 1'b1;
            end
        end
        if (bg_read && !bg_read_q) begin
            dl_act_d = 1'b1;
            dl_cnt_d = DLW'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            owner_q        <= 1'b0;
            rom_addr_q     <= '0;
            rom_req_q      <= 1'b0;
            wdog_q         <= '0;
            bg_run_q       <= '0;
            bg_data_q      <= '0;
            spr_data_q     <= '0;
            bg_valid_q     <= 1'b0;
            spr_valid_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            bg_srv_q       <= 1'b0;
            spr_srv_q      <= 1'b0;
            bg_srv_addr_q  <= '0;
            spr_srv_addr_q <= '0;
            bg_read_q      <= 1'b0;
            spr_read_q     <= 1'b0;
            dl_act_q       <= 1'b0;
            dl_cnt_q       <= '0;
            bg_late_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rom_addr_q     <= rom_addr_d;
            rom_req_q      <= rom_req_d;
            wdog_q         <= wdog_d;
            bg_run_q       <= bg_run_d;
            bg_data_q      <= bg_data_d;
            spr_data_q     <= spr_data_d;
            bg_valid_q     <= bg_valid_d;
            spr_valid_q    <= spr_valid_d;
            timeout_err_q  <= timeout_err_d;
            bg_srv_q       <= bg_srv_d;
            spr_srv_q      <= spr_srv_d;
            bg_srv_addr_q  <= bg_srv_addr_d;
            spr_srv_addr_q <= spr_srv_addr_d;
            bg_read_q      <= bg_read;
            spr_read_q     <= spr_read;
            dl_act_q       <= dl_act_d;
            dl_cnt_q       <= dl_cnt_d;
            bg_late_q      <= bg_late_d;
        end
    end

    assign bg_data     = bg_data_q;
    assign bg_valid    = bg_valid_q;
    assign spr_data    = spr_data_q;
    assign spr_valid   = spr_valid_q;
    assign rom_addr    = rom_addr_q;
    assign rom_req     = rom_req_q;
    assign busy        = (state_q == S_WAIT);
    assign timeout_err = timeout_err_q;
    assign bg_late     = bg_late_q;

endmodule

// File: tb/tb_vball_gfx_arb.sv
// Bench for vball_gfx_arb: scripted and randomized reads against a timing/data model of the arbiter.
module tb_vball_gfx_arb;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int TIMEOUT = 15;
    localparam int BG_RUN_MAX = 4;

    logic          clk_sys = 1'b0;
    logic          rst_n = 1'b0;
    logic          bg_read = 1'b0, spr_read = 1'b0;
    logic [AW-1:0] bg_addr = '0, spr_addr = '0;
    logic [DW-1:0] bg_data, spr_data;
    logic          bg_valid, spr_valid;
    logic [AW-1:0] rom_addr;
    logic          rom_req;
    logic          rom_ack = 1'b0;
    logic [DW-1:0] rom_data = '0;
    logic          busy, timeout_err, bg_late;

    vball_gfx_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .BG_RUN_MAX(BG_RUN_MAX), .BG_DEADLINE(8)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .bg_read(bg_read), .bg_addr(bg_addr), .bg_data(bg_data), .bg_valid(bg_valid),
        .spr_read(spr_read), .spr_addr(spr_addr), .spr_data(spr_data), .spr_valid(spr_valid),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
        .busy(busy), .timeout_err(timeout_err), .bg_late(bg_late)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt = 0;

    // Backend model: acks ack_dly cycles after rom_req is first seen, if enabled.
    int            ack_dly = 0;
    bit            ack_en = 1'b1;
    bit            ack_force = 1'b0;
    bit            fix_en = 1'b0;
    logic [DW-1:0] fix_val = '0;
    logic [DW-1:0] last_ack = '0;
    int            wcnt = 0;

    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            rom_data = DW'($urandom);
            if (rom_req) begin
                if (ack_en && wcnt == ack_dly) begin
                    rom_ack  = 1'b1;
                    rom_data = fix_en ? fix_val : DW'($urandom);
                    last_ack = rom_data;
                end else begin
                    rom_ack = ack_force;
                end
                wcnt++;
            end else begin
                rom_ack = ack_force;
                wcnt    = 0;
            end
        end
    end

    int to_cnt = 0, bgv_cnt = 0, sprv_cnt = 0;
    always @(negedge clk_sys) begin
        if (timeout_err) to_cnt <= to_cnt + 1;
        if (bg_valid)    bgv_cnt <= bgv_cnt + 1;
        if (spr_valid)   sprv_cnt <= sprv_cnt + 1;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        rst_n = 1'b0;
        bg_read = 1'b0;
        spr_read = 1'b0;
        repeat (3) @(posedge clk_sys);
        #2 rst_n = 1'b1;
    endtask

    // Issue one read and collect what the DUT did with it.
    task automatic run_txn(input bit spr, input logic [AW-1:0] addr, input int dly, input bit en,
                           output int lat, output int req_cycles, output logic [AW-1:0] gaddr,
                           output logic [DW-1:0] dat, output bit terr);
        int t0;
        bit prev;
        lat = -1; req_cycles = 0; gaddr = '0; dat = '0; terr = 1'b0; prev = 1'b0;
        ack_dly = dly;
        ack_en  = en;
        @(posedge clk_sys);
        #2;
        if (spr) begin spr_read = 1'b1; spr_addr = addr; end
        else begin bg_read = 1'b1; bg_addr = addr; end
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_sys);
            #2;
            if (rom_req) begin
                req_cycles++;
                if (!prev) gaddr = rom_addr;
            end
            prev = rom_req;
            if (spr ? spr_valid : bg_valid) begin
                lat  = cyc - t0;
                dat  = spr ? spr_data : bg_data;
                terr = timeout_err;
                break;
            end
        end
        bg_read  = 1'b0;
        spr_read = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #2;
        chk_cnt++; if (rom_req !== 1'b0) $display("FAIL reset_rom_req: got %b want 0", rom_req); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if ({bg_valid, spr_valid, timeout_err, bg_late} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {bg_valid, spr_valid, timeout_err, bg_late}); else pass_cnt++;
        chk_cnt++; if ({bg_data, spr_data} !== 16'h0) $display("FAIL reset_data: got %h want 0000", {bg_data, spr_data}); else pass_cnt++;
        chk_cnt++; if (rom_addr !== '0) $display("FAIL reset_rom_addr: got %h want 0", rom_addr); else pass_cnt++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_bg();
        int t0, vcyc, rises;
        bit prev;
        logic [AW-1:0] gaddr;
        logic [DW-1:0] vdat;
        fix_en = 1'b1; fix_val = 8'hA5; ack_dly = 0; ack_en = 1'b1;
        vcyc = -1; rises = 0; prev = 1'b0; gaddr = '0; vdat = '0;
        @(posedge clk_sys);
        #2 bg_read = 1'b1; bg_addr = 19'h12345;
        t0 = cyc;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_sys);
            #2;
            if (rom_req && !prev) begin rises++; gaddr = rom_addr; end
            prev = rom_req;
            if (bg_valid && vcyc < 0) begin vcyc = cyc; vdat = bg_data; end
        end
        bg_read = 1'b0;
        chk_cnt++; if (gaddr !== 19'h12345) $display("FAIL single_rom_addr: got %h want 12345", gaddr); else pass_cnt++;
        chk_cnt++; if (vdat !== 8'hA5) $display("FAIL single_data: got %h want a5", vdat); else pass_cnt++;
        chk_cnt++; if (vcyc - t0 !== 3) $display("FAIL single_latency: got %0d want 3", vcyc - t0); else pass_cnt++;
        chk_cnt++; if (rises !== 1) $display("FAIL single_no_regrant: got %0d grants want 1", rises); else pass_cnt++;
    endtask

    task automatic test_arb_fairness();
        int run, ngrant, nbg, nspr;
        bit prev, exp_spr;
        fix_en = 1'b0; ack_dly = 0; ack_en = 1'b1;
        run = 0; ngrant = 0; nbg = 0; nspr = 0; prev = 1'b0;
        @(posedge clk_sys);
        #2;
        bg_addr  = {1'b0, 18'($urandom)};
        spr_addr = {1'b1, 18'($urandom)};
        bg_read  = 1'b1;
        spr_read = 1'b1;
        for (int i = 0; i < 400 && (nbg + nspr) < 20; i++) begin
            @(posedge clk_sys);
            #2;
            if (rom_req && !prev) begin
                exp_spr = (run == BG_RUN_MAX);
                chk_cnt++;
                if (rom_addr !== (exp_spr ? spr_addr : bg_addr))
                    $display("FAIL arb_grant%0d: got addr %h want %h", ngrant, rom_addr, exp_spr ? spr_addr : bg_addr);
                else pass_cnt++;
                run = exp_spr ? 0 : run + 1;
                ngrant++;
            end
            prev = rom_req;
            if (bg_valid) begin
                chk_cnt++; if (bg_data !== last_ack) $display("FAIL arb_bg_data: got %h want %h", bg_data, last_ack); else pass_cnt++;
                nbg++;
                bg_addr[17:0] = bg_addr[17:0] + 18'd1 + 18'($urandom_range(0, 1000));
            end
            if (spr_valid) begin
                chk_cnt++; if (spr_data !== last_ack) $display("FAIL arb_spr_data: got %h want %h", spr_data, last_ack); else pass_cnt++;
                nspr++;
                spr_addr[17:0] = spr_addr[17:0] + 18'd1 + 18'($urandom_range(0, 1000));
            end
        end
        bg_read = 1'b0;
        spr_read = 1'b0;
        chk_cnt++; if (nbg + nspr !== 20) $display("FAIL arb_total: got %0d reads want 20", nbg + nspr); else pass_cnt++;
        chk_cnt++; if (nspr * 5 !== nbg + nspr) $display("FAIL arb_ratio: got %0d spr of %0d want one fifth", nspr, nbg + nspr); else pass_cnt++;
        for (int i = 0; i < 40 && busy; i++) @(posedge clk_sys);
        #2;
    endtask

    task automatic test_timeout();
        int lat, rc, t0;
        logic [AW-1:0] ga;
        logic [DW-1:0] d;
        bit te;
        fix_en = 1'b1; fix_val = DW'($urandom);
        t0 = to_cnt;
        run_txn(1'b0, 19'h0ABCD, 0, 1'b0, lat, rc, ga, d, te);
        chk_cnt++; if (rc !== TIMEOUT) $display("FAIL to_req_cycles: got %0d want %0d", rc, TIMEOUT); else pass_cnt++;
        chk_cnt++; if (d !== 8'hFF) $display("FAIL to_data: got %h want ff", d); else pass_cnt++;
        chk_cnt++; if (te !== 1'b1) $display("FAIL to_err_with_valid: got %b want 1", te); else pass_cnt++;
        chk_cnt++; if (lat !== 3 + TIMEOUT - 1) $display("FAIL to_latency: got %0d want %0d", lat, 3 + TIMEOUT - 1); else pass_cnt++;
        run_txn(1'b0, 19'h0ABCE, 3, 1'b1, lat, rc, ga, d, te);
        chk_cnt++; if (d !== fix_val || lat !== 6) $display("FAIL to_recover: got %h lat %0d want %h lat 6", d, lat, fix_val); else pass_cnt++;
        chk_cnt++; if (to_cnt - t0 !== 1) $display("FAIL to_err_count: got %0d want 1", to_cnt - t0); else pass_cnt++;
    endtask

    task automatic test_ack_at_limit();
        int lat, rc, t0;
        logic [AW-1:0] ga;
        logic [DW-1:0] d;
        bit te;
        fix_en = 1'b1; fix_val = 8'h3C;
        t0 = to_cnt;
        run_txn(1'b1, 19'h40010, TIMEOUT - 1, 1'b1, lat, rc, ga, d, te);
        chk_cnt++; if (d !== 8'h3C) $display("FAIL limit_data: got %h want 3c", d); else pass_cnt++;
        chk_cnt++; if (lat !== 3 + TIMEOUT - 1) $display("FAIL limit_latency: got %0d want %0d", lat, 3 + TIMEOUT - 1); else pass_cnt++;
        chk_cnt++; if (to_cnt - t0 !== 0 || te !== 1'b0) $display("FAIL limit_no_err: got %0d pulses want 0", to_cnt - t0); else pass_cnt++;
    endtask

    task automatic test_random_reads();
        int lat, rc, dly, a, exp_lat, exp_rc;
        logic [AW-1:0] ga, addr;
        logic [DW-1:0] d, exp_d;
        bit te, en, spr;
        fix_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            spr     = 1'($urandom_range(0, 1));
            dly     = $urandom_range(0, 20);
            en      = ($urandom_range(0, 3) != 0);
            addr    = AW'($urandom);
            fix_val = DW'($urandom);
            a       = (en && dly < TIMEOUT) ? dly : -1;
            exp_lat = 3 + ((a >= 0) ? a : TIMEOUT - 1);
            exp_rc  = (a >= 0) ? a + 1 : TIMEOUT;
            exp_d   = (a >= 0) ? fix_val : 8'hFF;
            run_txn(spr, addr, dly, en, lat, rc, ga, d, te);
            chk_cnt++; if (ga !== addr) $display("FAIL rnd%0d_addr: got %h want %h", k, ga, addr); else pass_cnt++;
            chk_cnt++; if (d !== exp_d) $display("FAIL rnd%0d_data: got %h want %h", k, d, exp_d); else pass_cnt++;
            chk_cnt++; if (lat !== exp_lat || rc !== exp_rc) $display("FAIL rnd%0d_timing: got lat %0d req %0d want lat %0d req %0d", k, lat, rc, exp_lat, exp_rc); else pass_cnt++;
            chk_cnt++; if (te !== (a < 0)) $display("FAIL rnd%0d_err: got %b want %b", k, te, (a < 0)); else pass_cnt++;
        end
    endtask

    task automatic test_bg_late();
        int lat, rc;
        logic [AW-1:0] ga;
        logic [DW-1:0] d;
        bit te;
        fix_en = 1'b0;
        do_reset();
        chk_cnt++; if (bg_late !== 1'b0) $display("FAIL late_after_reset: got %b want 0", bg_late); else pass_cnt++;
        run_txn(1'b0, 19'h00100, 2, 1'b1, lat, rc, ga, d, te);
        chk_cnt++; if (bg_late !== 1'b0) $display("FAIL late_on_time: got %b want 0 (lat %0d)", bg_late, lat); else pass_cnt++;
        run_txn(1'b0, 19'h00200, 9, 1'b1, lat, rc, ga, d, te);
        chk_cnt++; if (bg_late !== 1'b1) $display("FAIL late_missed: got %b want 1 (lat %0d)", bg_late, lat); else pass_cnt++;
        for (int k = 0; k < 2; k++) run_txn(1'b0, 19'h00300 + 19'(k), 0, 1'b1, lat, rc, ga, d, te);
        repeat (3) @(posedge clk_sys);
        #2;
        chk_cnt++; if (bg_late !== 1'b1) $display("FAIL late_sticky: got %b want 1", bg_late); else pass_cnt++;
    endtask

    task automatic test_reset_mid_wait();
        int v0, nz;
        ack_en = 1'b0;
        @(posedge clk_sys);
        #2 bg_read = 1'b1; bg_addr = 19'h05555;
        for (int i = 0; i < 20 && !busy; i++) begin @(posedge clk_sys); #2; end
        chk_cnt++; if (busy !== 1'b1) $display("FAIL rst_wait_entry: busy %b want 1", busy); else pass_cnt++;
        repeat (3) @(posedge clk_sys);
        #3 rst_n = 1'b0;
        #1;
        chk_cnt++; if (rom_req !== 1'b0 || busy !== 1'b0) $display("FAIL rst_async_drop: req %b busy %b want 0 0", rom_req, busy); else pass_cnt++;
        chk_cnt++; if (bg_late !== 1'b0) $display("FAIL rst_late_clear: got %b want 0", bg_late); else pass_cnt++;
        bg_read = 1'b0;
        v0 = bgv_cnt + sprv_cnt;
        repeat (2) @(posedge clk_sys);
        #2 rst_n = 1'b1;
        ack_force = 1'b1;
        @(posedge clk_sys);
        #2 ack_force = 1'b0;
        nz = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_sys);
            #2;
            if ({bg_valid, spr_valid, rom_req, busy, timeout_err, bg_late} !== 6'b0 || {bg_data, spr_data} !== 16'h0) nz++;
        end
        chk_cnt++; if (nz !== 0) $display("FAIL rst_spurious_ack: %0d cycles with nonzero outputs want 0", nz); else pass_cnt++;
        chk_cnt++; if (bgv_cnt + sprv_cnt - v0 !== 0) $display("FAIL rst_no_valid: got %0d pulses want 0", bgv_cnt + sprv_cnt - v0); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_bg();
        test_arb_fairness();
        test_timeout();
        test_ack_at_limit();
        test_random_reads();
        test_bg_late();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
